// File: rtl/button_debounce_ctrl_if.sv
// rtl/button_debounce_ctrl_if.sv - raw button pad in, debounced level/strobes/LED out
interface button_debounce_ctrl_if;
    logic button;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;
    logic ledg;

    modport master (
        output button,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_pulse,
        input  ledg
    );

    modport slave (
        input  button,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_pulse,
        output ledg
    );
endinterface

// File: rtl/button_debounce_ctrl.sv
// rtl/button_debounce_ctrl.sv - synchronise, debounce and sequence one push-button into press/release/long strobes
module button_debounce_ctrl #(
    parameter int DB_CYCLES   = 500000,
    parameter int LONG_CYCLES = 50000000,
    parameter int CNT_W       = 26,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    button_debounce_ctrl_if.slave   bus
);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic             PAD_POL   = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_UP      = 3'd0,
        S_DN_WAIT = 3'd1,
        S_DOWN    = 3'd2,
        S_LONG    = 3'd3,
        S_UP_WAIT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
    logic             long_flag_q, long_flag_d;
    logic             sync1_q, sync2_q;
    logic             btn_level_q, btn_level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             ledg_q, ledg_d;
    logic             btn_s;

    assign btn_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        l_cnt_d     = l_cnt_q;
        long_flag_d = long_flag_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        ledg_d      = ledg_q;
        case (state_q)
            S_UP: begin
                if (btn_s) begin
                    state_d  = S_DN_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_DN_WAIT: begin
                if (!btn_s) begin
                    state_d = S_UP;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = S_DOWN;
                    l_cnt_d     = '0;
                    long_flag_d = 1'b0;
                    press_d     = 1'b1;
                    ledg_d      = ~ledg_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            S_DOWN: begin
                if (!btn_s) begin
                    state_d  = S_UP_WAIT;
                    db_cnt_d = '0;
                end else if (l_cnt_q == LONG_LAST) begin
                    state_d     = S_LONG;
                    long_flag_d = 1'b1;
                    long_d      = 1'b1;
                    ledg_d      = 1'b0;
                end else begin
                    l_cnt_d = l_cnt_q + 1'b1;
                end
            end
            S_LONG: begin
                long_flag_d = 1'b1;
                if (!btn_s) begin
                    state_d  = S_UP_WAIT;
                    db_cnt_d = '0;
                end
            end
            S_UP_WAIT: begin
                // A bounce back to pressed resumes the hold without an event; l_cnt keeps its value.
                if (btn_s) begin
                    state_d = long_flag_q ? S_LONG : S_DOWN;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = S_UP;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_UP;
            end
        endcase
        btn_level_d = (state_d == S_DOWN) || (state_d == S_LONG) || (state_d == S_UP_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_UP;
            db_cnt_q    <= '0;
            l_cnt_q     <= '0;
            long_flag_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            btn_level_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            ledg_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            l_cnt_q     <= l_cnt_d;
            long_flag_q <= long_flag_d;
            sync1_q     <= bus.button ^ PAD_POL;
            sync2_q     <= sync1_q;
            btn_level_q <= btn_level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            ledg_q      <= ledg_d;
        end
    end

    assign bus.btn_level     = btn_level_q;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.ledg          = ledg_q;
endmodule
